// File: rtl/multi_pulse_pkg.sv
// Shared types for the multi-channel pulse generator.
// Optional duty-cycle feature: define MULTI_PULSE_GEN_DUTY_EN.
package multi_pulse_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } pulse_state_t;

    typedef enum logic {
        M_PERIODIC = 1'b0,
        M_ONESHOT  = 1'b1
    } pulse_mode_t;

    localparam int unsigned DEF_N        = 8;
    localparam int unsigned DEF_CHANNELS = 4;

endpackage

// File: rtl/pulse_channel.sv
// One pulse channel: IDLE/RUN FSM, period counter and shadow period/mode/width.
// MULTI_PULSE_GEN_DUTY_EN adds a width input giving the high-time per period.
module pulse_channel
    import multi_pulse_pkg::*;
#(
    parameter int unsigned N = DEF_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         start,
    input  logic         stop,
    input  logic         mode,
    input  logic [N-1:0] ticks,
`ifdef MULTI_PULSE_GEN_DUTY_EN
    input  logic [N-1:0] width,
`endif
    output logic         out,
    output logic         busy,
    output logic         done
);

    pulse_state_t state_q, state_d;
    pulse_mode_t  mode_q,  mode_d;
    logic [N-1:0] cnt_q,   cnt_d;
    logic [N-1:0] per_q,   per_d;
    logic [N-1:0] per_new;
    logic         last;
    logic         act;
    logic         in_win;
`ifdef MULTI_PULSE_GEN_DUTY_EN
    logic [N-1:0] wid_q, wid_d;
    logic [N-1:0] wid_new;
`endif

    // Shadow-load values, end-of-period detect and the combinational outputs
    always_comb begin
        per_new = (ticks == '0) ? N'(1) : ticks;
        last    = (cnt_q == per_q - N'(1));
        // start or stop in RUN suppresses any pulse that cycle
        act     = (state_q == S_RUN) && ena && !stop && !start;
`ifdef MULTI_PULSE_GEN_DUTY_EN
        wid_new = (width > per_new) ? per_new : width;
        in_win  = (cnt_q >= per_q - wid_q) && (wid_q != '0);
`else
        in_win  = last;
`endif
        out  = act && in_win;
        done = act && last && (mode_q == M_ONESHOT);
        busy = (state_q == S_RUN);
    end

    // Next-state: stop beats start, start (re)triggers, ena advances the count
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
`ifdef MULTI_PULSE_GEN_DUTY_EN
        wid_d   = wid_q;
`endif
        if (state_q == S_IDLE) begin
            if (start && !stop) begin
                state_d = S_RUN;
                mode_d  = pulse_mode_t'(mode);
                cnt_d   = '0;
                per_d   = per_new;
`ifdef MULTI_PULSE_GEN_DUTY_EN
                wid_d   = wid_new;
`endif
            end
        end else begin
            if (stop) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else if (start) begin
                mode_d  = pulse_mode_t'(mode);
                cnt_d   = '0;
                per_d   = per_new;
`ifdef MULTI_PULSE_GEN_DUTY_EN
                wid_d   = wid_new;
`endif
            end else if (ena) begin
                if (last) begin
                    cnt_d = '0;
                    if (mode_q == M_ONESHOT) begin
                        state_d = S_IDLE;
                    end else begin
                        per_d = per_new;
`ifdef MULTI_PULSE_GEN_DUTY_EN
                        wid_d = wid_new;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + N'(1);
                end
            end
        end
    end

    // State and shadow registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= M_PERIODIC;
            cnt_q   <= '0;
            per_q   <= '0;
`ifdef MULTI_PULSE_GEN_DUTY_EN
            wid_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
`ifdef MULTI_PULSE_GEN_DUTY_EN
            wid_q   <= wid_d;
`endif
        end
    end

endmodule

// File: rtl/multi_pulse_generator.sv
// Multi-channel programmable pulse generator; one pulse_channel per channel.
// Define MULTI_PULSE_GEN_DUTY_EN to add the per-channel width (duty) port.
module multi_pulse_generator
    import multi_pulse_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned CHANNELS = DEF_CHANNELS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   ena,
    input  logic [CHANNELS-1:0]   start,
    input  logic [CHANNELS-1:0]   stop,
    input  logic [CHANNELS-1:0]   mode,
    input  logic [CHANNELS*N-1:0] ticks,
`ifdef MULTI_PULSE_GEN_DUTY_EN
    input  logic [CHANNELS*N-1:0] width,
`endif
    output logic [CHANNELS-1:0]   out,
    output logic [CHANNELS-1:0]   busy,
    output logic [CHANNELS-1:0]   done
);

    // Independent channels; the top only slices the buses
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pulse_channel #(.N(N)) u_ch (
            .clk   (clk),
            .rst   (rst),
            .ena   (ena[i]),
            .start (start[i]),
            .stop  (stop[i]),
            .mode  (mode[i]),
            .ticks (ticks[i*N +: N]),
`ifdef MULTI_PULSE_GEN_DUTY_EN
            .width (width[i*N +: N]),
`endif
            .out   (out[i]),
            .busy  (busy[i]),
            .done  (done[i])
        );
    end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Bench for multi_pulse_generator: directed scenarios plus random traffic,
// every cycle compared against a countdown-based reference model.
// Define MULTI_PULSE_GEN_DUTY_EN to exercise the width port.
module tb_multi_pulse_generator;

    localparam int unsigned N  = 8;
    localparam int unsigned CH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   ena, start, stop, mode;
    logic [CH*N-1:0] ticks;
`ifdef MULTI_PULSE_GEN_DUTY_EN
    logic [CH*N-1:0] width;
`endif
    logic [CH-1:0]   out, busy, done;

    int total = 0;
    int bad   = 0;

    // Model: per channel, running flag, enabled cycles left in the period
    // (the last one being 1), high-time and one-shot flag.
    bit m_run [CH];
    int m_rem [CH];
    int m_wid [CH];
    bit m_one [CH];

    multi_pulse_generator #(.N(N), .CHANNELS(CH)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .ticks (ticks),
`ifdef MULTI_PULSE_GEN_DUTY_EN
        .width (width),
`endif
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int i);
        int t;
        t = int'(ticks[i*N +: N]);
        m_rem[i] = (t == 0) ? 1 : t;
`ifdef MULTI_PULSE_GEN_DUTY_EN
        m_wid[i] = (int'(width[i*N +: N]) > m_rem[i]) ? m_rem[i] : int'(width[i*N +: N]);
`else
        m_wid[i] = 1;
`endif
        m_one[i] = mode[i];
    endtask

    // Sample at the falling edge and compare against the model
    task automatic tick_check();
        logic [CH-1:0] e_out, e_busy, e_done;
        @(negedge clk);
        e_out = '0; e_busy = '0; e_done = '0;
        for (int i = 0; i < CH; i++) begin
            bit act;
            act       = m_run[i] && ena[i] && !stop[i] && !start[i];
            e_busy[i] = m_run[i];
            e_out[i]  = act && (m_rem[i] <= m_wid[i]);
            e_done[i] = act && (m_rem[i] == 1) && m_one[i];
        end
        chk("out",  32'(out),  32'(e_out));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
    endtask

    // Advance one clock, updating the model with the inputs of that cycle
    task automatic tick_adv();
        @(posedge clk);
        for (int i = 0; i < CH; i++) begin
            if (rst) begin
                m_run[i] = 1'b0;
            end else if (m_run[i]) begin
                if (stop[i]) m_run[i] = 1'b0;
                else if (start[i]) load(i);
                else if (ena[i]) begin
                    if (m_rem[i] == 1) begin
                        if (m_one[i]) m_run[i] = 1'b0;
                        else load_period(i);
                    end else begin
                        m_rem[i] = m_rem[i] - 1;
                    end
                end
            end else if (start[i] && !stop[i]) begin
                m_run[i] = 1'b1;
                load(i);
            end
        end
        #1;
    endtask

    // Periodic wrap: new period and width from current inputs, mode kept
    task automatic load_period(input int i);
        bit keep;
        keep = m_one[i];
        load(i);
        m_one[i] = keep;
    endtask

    task automatic cyc();
        tick_check();
        tick_adv();
    endtask

    task automatic set_ticks(input int i, input int v);
        ticks[i*N +: N] = N'(v);
    endtask

    initial begin
        rst = 1'b1; ena = '1; start = '0; stop = '0; mode = '0; ticks = '0;
`ifdef MULTI_PULSE_GEN_DUTY_EN
        width = '0;
`endif
        for (int i = 0; i < CH; i++) begin
            m_run[i] = 1'b0; m_rem[i] = 1; m_wid[i] = 1; m_one[i] = 1'b0;
        end
        @(posedge clk); #1;

        // 1: reset held, then released
        for (int c = 0; c < 3; c++) cyc();
        rst = 1'b0;
        tick_check();
        chk("rst_out",  32'(out),  32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        tick_adv();

        // 2: ch0 periodic, ticks=4
        set_ticks(0, 4); mode[0] = 1'b0; start[0] = 1'b1;
        cyc();
        start[0] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick_check();
            chk($sformatf("t2_out_c%0d", c), 32'(out[0]), 32'((c % 4) == 0));
            chk($sformatf("t2_busy_c%0d", c), 32'(busy[0]), 32'd1);
            tick_adv();
        end
        stop[0] = 1'b1; cyc(); stop[0] = 1'b0;

        // 3: ch1 one-shot, ticks=3
        set_ticks(1, 3); mode[1] = 1'b1; start[1] = 1'b1;
        cyc();
        start[1] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick_check();
            chk($sformatf("t3_out_c%0d", c), 32'(out[1]), 32'(c == 3));
            chk($sformatf("t3_done_c%0d", c), 32'(done[1]), 32'(c == 3));
            chk($sformatf("t3_busy_c%0d", c), 32'(busy[1]), 32'(c <= 3));
            tick_adv();
        end

        // 4: ch0 ticks=5 with ena low cycles 2-4
        set_ticks(0, 5); mode[0] = 1'b0; start[0] = 1'b1;
        cyc();
        start[0] = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            ena[0] = !(c >= 2 && c <= 4);
            tick_check();
            chk($sformatf("t4_out_c%0d", c), 32'(out[0]), 32'(c == 8));
            tick_adv();
        end
        ena[0] = 1'b1;
        stop[0] = 1'b1; cyc(); stop[0] = 1'b0;

        // 5: start+stop together in RUN, then retrigger at count 2
        set_ticks(2, 4); mode[2] = 1'b0; start[2] = 1'b1;
        cyc();
        start[2] = 1'b0;
        cyc(); cyc(); cyc();
        start[2] = 1'b1; stop[2] = 1'b1;
        tick_check();
        chk("t5_ss_out", 32'(out[2]), 32'd0);
        tick_adv();
        start[2] = 1'b0; stop[2] = 1'b0;
        tick_check();
        chk("t5_ss_busy", 32'(busy[2]), 32'd0);
        tick_adv();
        start[2] = 1'b1;
        cyc();
        start[2] = 1'b0;
        cyc(); cyc();
        start[2] = 1'b1;
        tick_check();
        chk("t5_rt_out", 32'(out[2]), 32'd0);
        tick_adv();
        start[2] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick_check();
            chk($sformatf("t5_rt_out_c%0d", c), 32'(out[2]), 32'(c == 4));
            tick_adv();
        end
        stop[2] = 1'b1; cyc(); stop[2] = 1'b0;

`ifdef MULTI_PULSE_GEN_DUTY_EN
        // 6: duty width 2 of 6, then width 0
        set_ticks(3, 6); width[3*N +: N] = N'(2); mode[3] = 1'b0; start[3] = 1'b1;
        cyc();
        start[3] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick_check();
            chk($sformatf("t6_out_c%0d", c), 32'(out[3]), 32'((c % 6) == 5 || (c % 6) == 0));
            tick_adv();
        end
        width[3*N +: N] = '0; start[3] = 1'b1;
        cyc();
        start[3] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick_check();
            chk($sformatf("t6_w0_out_c%0d", c), 32'(out[3]), 32'd0);
            tick_adv();
        end
        stop[3] = 1'b1; cyc(); stop[3] = 1'b0;
`endif

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < CH; i++) begin
                ena[i]   = ($urandom_range(0, 7) != 0);
                start[i] = ($urandom_range(0, 11) == 0);
                stop[i]  = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 15) == 0) mode[i] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) set_ticks(i, int'($urandom_range(0, 7)));
`ifdef MULTI_PULSE_GEN_DUTY_EN
                if ($urandom_range(0, 7) == 0) width[i*N +: N] = N'($urandom_range(0, 8));
`endif
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
